// File: rtl/interrupt_controller.sv
// interrupt_controller: synchronised edge/level interrupt capture with mask, fixed priority and ack/reti handshake
module interrupt_controller #(
  parameter int                 NUM_INT     = 8,
  parameter int                 SYNC_STAGES = 3,
  parameter logic [NUM_INT-1:0] LEVEL_MODE  = '0,
  parameter logic [26:0]        VECTOR_BASE = 27'd1,
  parameter int                 ID_W        = (NUM_INT > 1) ? $clog2(NUM_INT) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_INT-1:0] int_in,
  input  logic               enable,
  input  logic               mask_we,
  input  logic [NUM_INT-1:0] mask_d,
  output logic [NUM_INT-1:0] mask_q,
  output logic [NUM_INT-1:0] pending_q,
  output logic [NUM_INT-1:0] overflow_q,
  input  logic [NUM_INT-1:0] ovf_clr,
  output logic               irq,
  output logic [ID_W-1:0]    irq_id,
  output logic [26:0]        irq_vector,
  input  logic               ack,
  input  logic               reti,
  output logic               in_service
);
  logic [SYNC_STAGES-1:0][NUM_INT-1:0] sync_q;
  logic [NUM_INT-1:0] prev_q, s, rise, set_v, clr, elig, pending_d, overflow_d;
  logic               ack_fire, irq_d, svc_d;
  logic [ID_W-1:0]    cand, id_d;
  always_comb begin
    s          = sync_q[SYNC_STAGES-1];
    rise       = s & ~prev_q;
    set_v      = (LEVEL_MODE & s) | (~LEVEL_MODE & rise);
    ack_fire   = ack & irq;
    clr        = ack_fire ? (NUM_INT'(1) << irq_id) : '0;
    pending_d  = (pending_q & ~clr) | set_v;
    overflow_d = (overflow_q & ~ovf_clr) | (~LEVEL_MODE & rise & pending_q & ~clr);
    elig       = pending_q & mask_q;
    cand       = '0;
    for (int i = NUM_INT - 1; i >= 0; i--) cand = elig[i] ? ID_W'(i) : cand;
    // a presented channel is held until ack; it only drops if it loses eligibility
    irq_d      = enable & ~in_service & ~ack & (irq ? elig[irq_id] : |elig);
    id_d       = (irq_d & ~irq) ? cand : irq_id;
    svc_d      = (in_service & ~reti) | ack_fire;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q     <= '0;
      prev_q     <= '0;
      mask_q     <= '0;
      pending_q  <= '0;
      overflow_q <= '0;
      irq        <= 1'b0;
      irq_id     <= '0;
      irq_vector <= VECTOR_BASE;
      in_service <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], int_in};
      prev_q     <= s;
      mask_q     <= mask_we ? mask_d : mask_q;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      irq        <= irq_d;
      irq_id     <= id_d;
      irq_vector <= VECTOR_BASE + 27'(id_d);
      in_service <= svc_d;
    end
  end
endmodule

// File: tb/tb_interrupt_controller.sv
// tb_interrupt_controller: scoreboard bench; expected presentations queued at stimulus, checked on each irq rise
module tb_interrupt_controller;
  logic        clk = 0, reset = 1, enable = 0, mask_we = 0, ack = 0, reti = 0;
  logic [7:0]  int_in = 0, mask_d = 0, ovf_clr = 0;
  logic [7:0]  mask_q, pending_q, overflow_q;
  logic        irq, in_service;
  logic [2:0]  irq_id;
  logic [26:0] irq_vector;
  int          checks = 0, failures = 0;
  logic        irq_prev = 0;
  typedef struct {logic [2:0] id; logic [26:0] vec;} exp_t;
  exp_t        sb_q[$];

  interrupt_controller #(.LEVEL_MODE(8'h10)) dut (
    .clk(clk), .reset(reset), .int_in(int_in), .enable(enable), .mask_we(mask_we),
    .mask_d(mask_d), .mask_q(mask_q), .pending_q(pending_q), .overflow_q(overflow_q),
    .ovf_clr(ovf_clr), .irq(irq), .irq_id(irq_id), .irq_vector(irq_vector),
    .ack(ack), .reti(reti), .in_service(in_service)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_irq(input logic [2:0] id);
    exp_t e;
    e.id  = id;
    e.vec = 27'd1 + 27'(id);
    sb_q.push_back(e);
  endtask

  task automatic set_mask(input logic [7:0] m);
    mask_we = 1; mask_d = m;
    tick(1);
    mask_we = 0;
  endtask

  task automatic do_ack;
    ack = 1; tick(1); ack = 0;
  endtask

  task automatic do_reti;
    reti = 1; tick(1); reti = 0;
  endtask

  always @(negedge clk) begin
    if (irq && !irq_prev) begin
      if (sb_q.size() == 0) chk("sb_unexpected_irq", {61'd0, irq_id}, 64'h7f);
      else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("sb_id", {61'd0, irq_id}, {61'd0, e.id});
        chk("sb_vec", {37'd0, irq_vector}, {37'd0, e.vec});
      end
    end
    irq_prev <= irq;
  end

  initial begin
    tick(3);
    chk("rst_irq", irq, 0);
    chk("rst_vec", irq_vector, 1);
    chk("rst_id", irq_id, 0);
    chk("rst_mask", mask_q, 0);
    chk("rst_pend", pending_q, 0);
    chk("rst_svc", in_service, 0);
    reset = 0;
    tick(2);
    // single edge on channel 0
    set_mask(8'h01);
    enable = 1;
    chk("mask_write", mask_q, 8'h01);
    int_in[0] = 1;
    expect_irq(0);
    tick(3);
    chk("lat_pend_early", pending_q, 0);
    tick(1);
    chk("lat_pend", pending_q, 8'h01);
    chk("lat_irq_early", irq, 0);
    tick(1);
    chk("lat_irq", irq, 1);
    tick(1);
    do_ack;
    chk("ack_irq", irq, 0);
    chk("ack_svc", in_service, 1);
    chk("ack_pend", pending_q, 0);
    int_in[0] = 0;
    do_reti;
    chk("reti_svc", in_service, 0);
    tick(4);
    // simultaneous edges: lower index wins
    set_mask(8'hff);
    int_in[5] = 1; int_in[2] = 1;
    expect_irq(2); expect_irq(5);
    tick(5);
    chk("prio_pend", pending_q, 8'h24);
    chk("prio_id", irq_id, 2);
    do_ack;
    do_reti;
    tick(1);
    chk("prio_second", irq_id, 5);
    do_ack;
    do_reti;
    int_in = 0;
    tick(4);
    // no preemption and no nesting
    int_in[3] = 1;
    expect_irq(3);
    tick(5);
    int_in[0] = 1;
    tick(5);
    chk("nopre_pend", pending_q, 8'h09);
    chk("nopre_id", irq_id, 3);
    do_ack;
    tick(3);
    chk("nonest_irq", irq, 0);
    expect_irq(0);
    do_reti;
    tick(1);
    chk("nonest_after", irq_id, 0);
    do_ack;
    do_reti;
    int_in = 0;
    tick(4);
    // two edges on channel 1 before ack
    expect_irq(1);
    int_in[1] = 1; tick(2); int_in[1] = 0; tick(2);
    int_in[1] = 1; tick(2); int_in[1] = 0;
    tick(6);
    chk("ovf_flag", overflow_q, 8'h02);
    chk("ovf_pend", pending_q, 8'h02);
    ovf_clr = 8'h02; tick(1); ovf_clr = 0;
    chk("ovf_clr", overflow_q, 0);
    do_ack;
    do_reti;
    tick(2);
    // level channel 4 re-asserts while held high
    int_in[4] = 1;
    expect_irq(4);
    tick(5);
    do_ack;
    chk("lvl_pend_hold", pending_q, 8'h10);
    expect_irq(4);
    do_reti;
    tick(1);
    chk("lvl_reirq", irq, 1);
    int_in[4] = 0;
    tick(4);
    do_ack;
    chk("lvl_pend_clr", pending_q, 0);
    do_reti;
    tick(4);
    chk("lvl_noirq", irq, 0);
    chk("lvl_noovf", overflow_q, 0);
    // masked channel accumulates, unmask presents next edge
    set_mask(8'hbf);
    int_in[6] = 1;
    tick(6);
    chk("mask_pend", pending_q, 8'h40);
    chk("mask_noirq", irq, 0);
    expect_irq(6);
    set_mask(8'hff);
    chk("unmask_early", irq, 0);
    tick(1);
    chk("unmask_irq", irq, 1);
    do_ack;
    chk("pre_rst_svc", in_service, 1);
    // asynchronous reset mid-handler
    #2 reset = 1;
    #1;
    chk("arst_svc", in_service, 0);
    chk("arst_mask", mask_q, 0);
    chk("arst_vec", irq_vector, 1);
    chk("arst_pend", pending_q, 0);
    tick(2);
    reset = 0;
    tick(5);
    chk("rst_release_edge", pending_q, 8'h40);
    chk("rst_release_irq", irq, 0);
    set_mask(8'hff);
    enable = 0;
    tick(2);
    chk("en_low_irq", irq, 0);
    enable = 1;
    expect_irq(6);
    tick(1);
    chk("en_high_irq", irq, 1);
    do_ack;
    do_reti;
    tick(3);
    chk("sb_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/interrupt_controller.md
# interrupt_controller

Parametrised interrupt controller replacing the fixed four-input interrupt stabilizers and hard-wired int1..int4 priority in the CPU. Accepts NUM_INT asynchronous request lines, synchronises them, latches per-channel pending bits (edge or level mode), applies a software mask and fixed priority, and presents a single registered request with channel ID and jump vector to the PC/control unit. Uses an ack/reti handshake with one in-service level (no nesting).

## Interface
- NUM_INT, 8: number of interrupt channels (1..32).
- SYNC_STAGES, 3: synchroniser flops per channel (>=2).
- LEVEL_MODE, 0: NUM_INT-bit mask; bit i = 1 selects level mode for channel i, 0 selects rising-edge mode.
- VECTOR_BASE, 27'd1: address of channel 0 handler.
- ID_W, clog2(NUM_INT) (min 1): width of irq_id.

- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- int_in  in  NUM_INT  raw asynchronous request lines.
- enable  in  1  global interrupt enable.
- mask_we  in  1  write strobe for mask register.
- mask_d  in  NUM_INT  new mask (1 = channel enabled).
- mask_q  out  NUM_INT  current mask.
- pending_q  out  NUM_INT  current pending bits.
- overflow_q  out  NUM_INT  sticky "edge lost while pending" flags.
- ovf_clr  in  NUM_INT  write-1-to-clear for overflow_q.
- irq  out  1  registered interrupt request.
- irq_id  out  ID_W  channel being presented.
- irq_vector  out  27  VECTOR_BASE + irq_id.
- ack  in  1  single-cycle pulse: CPU has taken the jump.
- reti  in  1  single-cycle pulse: handler returned.
- in_service  out  1  a handler is active.

## Operation
- Reset values: sync chains 0, prev-sample 0, mask 0, pending 0, overflow 0, irq 0, irq_id 0, irq_vector VECTOR_BASE, in_service 0.
- Synchroniser: SYNC_STAGES flops per channel; s_i = last stage.
- Edge channel: pending_i set when s_i & ~prev_i. If pending_i already 1 at that edge and not simultaneously acked, overflow_i set.
- Level channel: pending_i set each cycle s_i = 1; never sets overflow.
- Pending set has priority over clear by ack in the same cycle (new edge or still-high level stays pending).
- Eligible = pending & mask; candidate = lowest-index eligible bit (channel 0 highest priority).
- irq_next = enable & ~in_service & |eligible & ~ack.
- While irq = 1, irq_id/irq_vector are frozen (no preemption before ack) unless the presented channel becomes ineligible (mask cleared, enable low), in which case irq drops next edge and re-arbitrates.
- ack while irq = 1: clear pending[irq_id], set in_service, irq low at same edge. ack while irq = 0: ignored.
- reti while in_service: clear in_service; arbitration resumes. reti while not in service: ignored. ack and reti same cycle: reti applied first, then ack (in_service ends 1).
- mask_we: mask updated at edge; pending bits of masked channels keep accumulating.
- ovf_clr bit i clears overflow_i unless a new overflow occurs that same cycle (set wins).
- irq_vector = VECTOR_BASE + irq_id, 27-bit wrap-around addition.

## Timing
- Latency: int_in high first sampled at edge k; pending set at edge k+SYNC_STAGES; irq, irq_id, irq_vector valid after edge k+SYNC_STAGES+1 (default: 4 edges after k).
- Input held high through reset release in edge mode produces one edge (sync chain resets to 0).
- Inputs must be high/low for at least one clk to be guaranteed captured.
- Reset asserted mid-handshake: all state cleared immediately; outstanding pending and in-service lost.
- All outputs registered; no combinational path from ack/reti/int_in to irq.

## Test plan
- Single edge: mask=0x01, enable=1, rise int_in[0] at edge 10 -> pending_q=0x01 at edge 13, irq=1, irq_id=0, irq_vector=1 after edge 14; ack at 16 -> irq=0, in_service=1, pending_q=0.
- Priority: edges on ch5 and ch2 same cycle, mask=0xFF -> irq_id=2, vector=3; ack, reti -> irq_id=5, vector=6 two edges later.
- No preemption/nesting: ch3 presented, ch0 edge arrives before ack -> irq_id stays 3; after ack ch0 not presented until reti.
- Overflow: two edges on ch1 before ack -> overflow_q[1]=1, single pending; ovf_clr=0x02 -> overflow_q=0.
- Level mode LEVEL_MODE=0x10: int_in[4] held high, ack, reti -> irq re-asserts with irq_id=4; drop input -> no further irq.
- Mask/enable/reset: pending ch6 with mask bit 0 -> irq=0; set mask -> irq=1 next edge; assert reset while in_service=1 -> all outputs to reset values asynchronously.
